// File: rtl/block_pkg.sv
// Shared encodings and ASCII constants for the token emitter.
// Imported by the emitter, its word ROM and the handshake interface users.
package block_pkg;

    typedef enum logic [1:0] {
        CMD_BEGIN = 2'b00,
        CMD_END   = 2'b01,
        CMD_SPACE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEP  = 2'b01,
        S_WORD = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        W_NONE  = 2'b00,
        W_BEGIN = 2'b01,
        W_END   = 2'b10
    } word_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6e;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_CASE  = 8'h20;

    localparam logic [2:0] LEN_BEGIN = 3'd5;
    localparam logic [2:0] LEN_END   = 3'd3;

    localparam logic [7:0] DEPTH_MAX = 8'hff;

    function automatic logic [7:0] to_upper(logic [7:0] c);
        return c - CH_CASE;
    endfunction

endpackage

// File: rtl/block_emitter_if.sv
// Command and character handshake bundle of the token emitter.
// slave is the emitter side, master the producer/consumer side.
interface block_emitter_if;
    logic [1:0] cmd;
    logic       cmd_upper;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] depth;
    logic       err;
    logic       balanced;

    modport slave (
        input  cmd,
        input  cmd_upper,
        input  cmd_valid,
        output cmd_ready,
        output out_char,
        output out_valid,
        input  out_ready,
        output depth,
        output err,
        output balanced
    );

    modport master (
        output cmd,
        output cmd_upper,
        output cmd_valid,
        input  cmd_ready,
        input  out_char,
        output out_ready,
        input  out_valid,
        input  depth,
        input  err,
        input  balanced
    );
endinterface

// File: rtl/block_word_rom.sv
// Combinational map of (word, index, case) to the ASCII letter.
// Out-of-range indexes and the empty word yield 0x00.
module block_word_rom
    import block_pkg::*;
(
    input  word_e      word,
    input  logic [2:0] index,
    input  logic       upper,
    output logic [7:0] ch
);

    logic [7:0] lc;

    always_comb begin
        lc = 8'h00;
        case (word)
            W_BEGIN: begin
                case (index)
                    3'd0:    lc = CH_B;
                    3'd1:    lc = CH_E;
                    3'd2:    lc = CH_G;
                    3'd3:    lc = CH_I;
                    3'd4:    lc = CH_N;
                    default: lc = 8'h00;
                endcase
            end
            W_END: begin
                case (index)
                    3'd0:    lc = CH_E;
                    3'd1:    lc = CH_N;
                    3'd2:    lc = CH_D;
                    default: lc = 8'h00;
                endcase
            end
            default: lc = 8'h00;
        endcase
    end

    assign ch = (upper && lc != 8'h00) ? to_upper(lc) : lc;

endmodule

// File: rtl/block_emitter.sv
// Token emitter: turns BEGIN/END/SPACE commands into a char stream
// while tracking nesting depth with a sticky saturation error.
module block_emitter
    import block_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    block_emitter_if.slave bus
);

    state_e     state;
    word_e      word;
    logic       upper;
    logic [2:0] index;
    logic [7:0] depth;
    logic       err;
    logic [7:0] rom_ch;
    logic [2:0] last;

    block_word_rom u_rom (
        .word  (word),
        .index (index),
        .upper (upper),
        .ch    (rom_ch)
    );

    assign last = (word == W_END) ? LEN_END - 3'd1
                                  : LEN_BEGIN - 3'd1;

    // cmd_ready is 1 only in IDLE, so valid in IDLE is acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            word  <= W_NONE;
            upper <= 1'b0;
            index <= 3'd0;
            depth <= 8'h00;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (cmd_e'(bus.cmd))
                            CMD_BEGIN: begin
                                word  <= W_BEGIN;
                                upper <= bus.cmd_upper;
                                index <= 3'd0;
                                state <= S_SEP;
                                if (depth == DEPTH_MAX) err <= 1'b1;
                                else depth <= depth + 8'd1;
                            end
                            CMD_END: begin
                                word  <= W_END;
                                upper <= bus.cmd_upper;
                                index <= 3'd0;
                                state <= S_SEP;
                                if (depth == 8'h00) err <= 1'b1;
                                else depth <= depth - 8'd1;
                            end
                            CMD_SPACE: begin
                                word  <= W_NONE;
                                state <= S_SEP;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_SEP: begin
                    if (bus.out_ready) begin
                        state <= (word == W_NONE) ? S_IDLE : S_WORD;
                    end
                end
                S_WORD: begin
                    if (bus.out_ready) begin
                        if (index == last) state <= S_IDLE;
                        else index <= index + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.out_valid = (state != S_IDLE);
    assign bus.out_char  = (state == S_SEP)  ? CH_SPACE :
                           (state == S_WORD) ? rom_ch : 8'h00;
    assign bus.depth     = depth;
    assign bus.err       = err;
    assign bus.balanced  = (depth == 8'h00) && !err;

endmodule

// File: tb/tb_block_emitter.sv
// Bench for block_emitter: vector table, corner sequences and a
// random run checked against a queue-based reference model.
module tb_block_emitter;

    logic clk;
    logic reset;
    block_emitter_if bus();

    block_emitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         m_depth = 0;
    bit         m_err = 0;
    bit         rand_rdy = 0;
    bit         hold_prev = 0;
    logic [7:0] prev_char = 8'h00;

    typedef struct {
        logic [1:0]  cmd;
        logic        upper;
        logic [47:0] s;
        int          n;
        int          depth;
        int          err;
        int          bal;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: each accepted command appends its text to the stream
    task automatic model_accept(logic [1:0] c, logic u);
        string w;
        w = "";
        if (c == 2'b11) return;
        if (c == 2'b00) begin
            if (u) w = "BEGIN";
            else w = "begin";
            if (m_depth == 255) m_err = 1;
            else m_depth++;
        end else if (c == 2'b01) begin
            if (u) w = "END";
            else w = "end";
            if (m_depth == 0) m_err = 1;
            else m_depth--;
        end
        exp_q.push_back(8'h20);
        for (int i = 0; i < w.len(); i++) exp_q.push_back(w[i]);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            if (bus.cmd_valid && bus.cmd_ready)
                model_accept(bus.cmd, bus.cmd_upper);
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back(bus.out_char);
                if (exp_q.size() == 0) begin
                    chk("unexpected_char", int'(bus.out_char), -1);
                end else begin
                    chk("stream_char", int'(bus.out_char),
                        int'(exp_q.pop_front()));
                end
            end
            if (!bus.out_valid)
                chk("idle_char_zero", int'(bus.out_char), 0);
            if (hold_prev) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_char", int'(bus.out_char), int'(prev_char));
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_char = bus.out_char;
        end else begin
            hold_prev = 0;
        end
    end

    task automatic check_flags(string tag);
        chk({tag, "_depth"}, int'(bus.depth), m_depth);
        chk({tag, "_err"}, int'(bus.err), int'(m_err));
        chk({tag, "_bal"}, int'(bus.balanced),
            int'(m_depth == 0 && !m_err));
    endtask

    task automatic send_cmd(logic [1:0] c, logic u);
        int g;
        g = 0;
        while (!bus.cmd_ready && g < 50) begin
            tick();
            g++;
        end
        if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
        bus.cmd       = c;
        bus.cmd_upper = u;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        if (c == 2'b11) begin
            chk("rsvd_valid", int'(bus.out_valid), 0);
            chk("rsvd_ready", int'(bus.cmd_ready), 1);
        end else begin
            chk("lat_valid", int'(bus.out_valid), 1);
            chk("lat_char", int'(bus.out_char), 'h20);
            chk("busy_ready", int'(bus.cmd_ready), 0);
        end
        check_flags("acc");
    endtask

    task automatic wait_idle(output int n);
        bit done;
        done = 0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.cmd_ready && !bus.out_valid) begin
                done = 1;
                break;
            end
            if (bus.out_valid) n++;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if (!done) chk("idle_timeout", 0, 1);
        bus.out_ready = 1'b1;
    endtask

    task automatic wait_char(logic [7:0] c);
        bit found;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid && bus.out_char == c) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) chk("char_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_depth = 0;
        m_err = 0;
        hold_prev = 0;
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_char", int'(bus.out_char), 0);
        check_flags("rst");
        tick();
        tick();
        #3;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int s0;
        logic [7:0] e;
        reset         = 1'b0;
        bus.cmd       = 2'b00;
        bus.cmd_upper = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{2'b00, 1'b0, " begin", 6, 1, 0, 0};
        vecs[1] = '{2'b01, 1'b0, " end",   4, 0, 0, 1};
        vecs[2] = '{2'b00, 1'b1, " BEGIN", 6, 1, 0, 0};
        vecs[3] = '{2'b01, 1'b1, " END",   4, 0, 0, 1};
        vecs[4] = '{2'b10, 1'b0, " ",      1, 0, 0, 1};
        vecs[5] = '{2'b11, 1'b1, 48'h0,    0, 0, 0, 1};
        vecs[6] = '{2'b01, 1'b0, " end",   4, 0, 1, 0};
        vecs[7] = '{2'b00, 1'b1, " BEGIN", 6, 1, 1, 0};
        vecs[8] = '{2'b01, 1'b0, " end",   4, 0, 1, 0};

        do_reset();

        foreach (vecs[v]) begin
            s0 = obs_q.size();
            send_cmd(vecs[v].cmd, vecs[v].upper);
            wait_idle(n);
            chk("vec_cycles", n, vecs[v].n);
            chk("vec_len", obs_q.size() - s0, vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++) begin
                e = vecs[v].s[8*(vecs[v].n-1-i) +: 8];
                if (s0 + i < obs_q.size())
                    chk("vec_char", int'(obs_q[s0+i]), int'(e));
            end
            chk("vec_depth", int'(bus.depth), vecs[v].depth);
            chk("vec_err", int'(bus.err), vecs[v].err);
            chk("vec_bal", int'(bus.balanced), vecs[v].bal);
        end

        // downstream stall while 'g' is on the output
        do_reset();
        s0 = obs_q.size();
        send_cmd(2'b00, 1'b0);
        wait_char(8'h67);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_char", int'(bus.out_char), 'h67);
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_ready", int'(bus.cmd_ready), 0);
        end
        bus.out_ready = 1'b1;
        wait_idle(n);
        chk("stall_len", obs_q.size() - s0, 6);
        chk("stall_queue", exp_q.size(), 0);

        // reset during 'e' aborts the word
        send_cmd(2'b00, 1'b0);
        wait_char(8'h65);
        s0 = obs_q.size();
        do_reset();
        chk("abort_len", obs_q.size() - s0, 0);
        s0 = obs_q.size();
        send_cmd(2'b10, 1'b0);
        wait_idle(n);
        chk("abort_space_cycles", n, 1);
        chk("abort_space_len", obs_q.size() - s0, 1);
        if (obs_q.size() > s0)
            chk("abort_space_char", int'(obs_q[s0]), 'h20);

        // depth saturation and the reserved code
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_cmd(2'b00, 1'($urandom_range(0, 1)));
            wait_idle(n);
            if (i == 254) begin
                chk("sat255_depth", int'(bus.depth), 255);
                chk("sat255_err", int'(bus.err), 0);
            end
        end
        chk("sat_depth", int'(bus.depth), 255);
        chk("sat_err", int'(bus.err), 1);
        chk("sat_bal", int'(bus.balanced), 0);
        s0 = obs_q.size();
        send_cmd(2'b11, 1'b0);
        wait_idle(n);
        chk("rsvd_cycles", n, 0);
        chk("rsvd_len", obs_q.size() - s0, 0);
        chk("rsvd_depth", int'(bus.depth), 255);
        chk("rsvd_err", int'(bus.err), 1);
        send_cmd(2'b01, 1'b0);
        wait_idle(n);
        chk("after_sat_depth", int'(bus.depth), 254);
        chk("after_sat_err", int'(bus.err), 1);

        // random commands with random downstream backpressure
        do_reset();
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            send_cmd(2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            wait_idle(n);
            check_flags("rand");
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 0;
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
